// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement adder/subtractor with start/done handshake.
// Optional signed-overflow output enabled by defining ADDSUB_OVF_EN.
module serial_addsub_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef ADDSUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addsub_unit: DIGIT must divide WIDTH exactly and WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sel_q, sel_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic             last_digit;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_next;

  assign accept     = start && (state_q == StIdle || state_q == StDone);
  assign last_digit = (cnt_q == CntW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (last_digit) state_d = StDone;
      StDone:  state_d = start ? StCalc : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == StCalc);
    done  = (state_q == StDone);
    sum   = sum_q;
    c_out = cout_q;
`ifdef ADDSUB_OVF_EN
    overflow = ovf_q;
`endif
  end

  // One digit slice per cycle; operands shift right so the active digit is always at bit 0.
  always_comb begin
    b_dig    = sel_q ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
    slice    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    res_next = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_d     = a;
      b_d     = b;
      sel_d   = select;
      carry_d = select;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == StCalc) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = slice[DIGIT];
      cnt_d   = cnt_q + CntW'(1);
      res_d   = res_next;
      if (last_digit) begin
        sum_d  = res_next;
        cout_d = slice[DIGIT];
`ifdef ADDSUB_OVF_EN
        // Same-sign operands producing an opposite-sign result == carry-in(MSB) ^ carry-out(MSB).
        ovf_d  = (a_q[DIGIT-1] == b_dig[DIGIT-1]) && (slice[DIGIT-1] != a_q[DIGIT-1]);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: vector table, random ops against an arithmetic
// model, and hand-written handshake/abort/reset sequences on 16/4, 4/4 and 4/2 instances.
module tb_serial_addsub_unit;

  logic clk;
  logic rst_n;

  logic        m_start, m_select, m_busy, m_done, m_cout;
  logic [15:0] m_a, m_b, m_sum;
  logic        s4_start, s4_select, s4_busy, s4_done, s4_cout;
  logic [3:0]  s4_a, s4_b, s4_sum;
  logic        s2_start, s2_select, s2_busy, s2_done, s2_cout;
  logic [3:0]  s2_a, s2_b, s2_sum;
`ifdef ADDSUB_OVF_EN
  logic        m_ovf, s4_ovf, s2_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .select(m_select), .a(m_a), .b(m_b),
    .busy(m_busy), .done(m_done), .sum(m_sum), .c_out(m_cout)
`ifdef ADDSUB_OVF_EN
    , .overflow(m_ovf)
`endif
  );

  serial_addsub_unit #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .select(s4_select), .a(s4_a), .b(s4_b),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .c_out(s4_cout)
`ifdef ADDSUB_OVF_EN
    , .overflow(s4_ovf)
`endif
  );

  serial_addsub_unit #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .select(s2_select), .a(s2_a), .b(s2_b),
    .busy(s2_busy), .done(s2_done), .sum(s2_sum), .c_out(s2_cout)
`ifdef ADDSUB_OVF_EN
    , .overflow(s2_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    longint cout;
    longint ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  // Reference: plain integer arithmetic on w-bit two's-complement values.
  function automatic res_t model(input int w, input longint a, input longint b, input logic sel);
    res_t   r;
    longint mask, full, sa, sb, sr, half;
    mask   = (longint'(1) << w) - 1;
    half   = longint'(1) << (w - 1);
    full   = a + (sel ? ((~b) & mask) : b) + (sel ? 1 : 0);
    r.sum  = full & mask;
    r.cout = (full >> w) & 1;
    sa     = (a >= half) ? a - (mask + 1) : a;
    sb     = (b >= half) ? b - (mask + 1) : b;
    sr     = sel ? sa - sb : sa + sb;
    r.ovf  = (sr < -half || sr >= half) ? 1 : 0;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_main_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (m_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_main_result(input string tag, input res_t e);
    check({tag, " sum"}, longint'(m_sum), e.sum);
    check({tag, " c_out"}, longint'(m_cout), e.cout);
`ifdef ADDSUB_OVF_EN
    check({tag, " ovf"}, longint'(m_ovf), e.ovf);
`endif
  endtask

  // Starts one op from IDLE, checks latency, result, and single-cycle done pulse.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sel,
                        input string tag);
    res_t e;
    int   lat;
    e        = model(16, longint'(a), longint'(b), sel);
    m_a      = a;
    m_b      = b;
    m_select = sel;
    m_start  = 1'b1;
    @(posedge clk); #1;
    m_start  = 1'b0;
    check({tag, " busy"}, longint'(m_busy), 1);
    wait_main_done(lat);
    check({tag, " latency"}, lat, 4);
    check_main_result(tag, e);
    @(posedge clk); #1;
    check({tag, " done pulse"}, longint'(m_done), 0);
  endtask

  // Runs one op on each 4-bit instance in parallel.
  task automatic run_small(input logic [3:0] a4, input logic [3:0] b4, input logic sel4,
                           input logic [3:0] a2, input logic [3:0] b2, input logic sel2,
                           input string tag);
    res_t e4, e2;
    int   lat4, lat2;
    e4 = model(4, longint'(a4), longint'(b4), sel4);
    e2 = model(4, longint'(a2), longint'(b2), sel2);
    s4_a = a4; s4_b = b4; s4_select = sel4; s4_start = 1'b1;
    s2_a = a2; s2_b = b2; s2_select = sel2; s2_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    s2_start = 1'b0;
    lat4 = -1;
    lat2 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (s4_done && lat4 < 0) begin
        lat4 = k;
        check({tag, " w4d4 sum"}, longint'(s4_sum), e4.sum);
        check({tag, " w4d4 c_out"}, longint'(s4_cout), e4.cout);
`ifdef ADDSUB_OVF_EN
        check({tag, " w4d4 ovf"}, longint'(s4_ovf), e4.ovf);
`endif
      end
      if (s2_done && lat2 < 0) begin
        lat2 = k;
        check({tag, " w4d2 sum"}, longint'(s2_sum), e2.sum);
        check({tag, " w4d2 c_out"}, longint'(s2_cout), e2.cout);
`ifdef ADDSUB_OVF_EN
        check({tag, " w4d2 ovf"}, longint'(s2_ovf), e2.ovf);
`endif
      end
    end
    check({tag, " w4d4 latency"}, lat4, 1);
    check({tag, " w4d2 latency"}, lat2, 2);
  endtask

  vec_t vecs[7];

  initial begin
    res_t e1, e2;
    int   lat;

    vecs[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0006, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    m_start = 0; m_select = 0; m_a = '0; m_b = '0;
    s4_start = 0; s4_select = 0; s4_a = '0; s4_b = '0;
    s2_start = 0; s2_select = 0; s2_a = '0; s2_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset busy", longint'(m_busy), 0);
    check("reset done", longint'(m_done), 0);
    check("reset sum", longint'(m_sum), 0);
    check("reset c_out", longint'(m_cout), 0);
`ifdef ADDSUB_OVF_EN
    check("reset ovf", longint'(m_ovf), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors with hand-derived expectations
    for (int i = 0; i < 7; i++) begin
      m_a = vecs[i].a; m_b = vecs[i].b; m_select = vecs[i].sel; m_start = 1'b1;
      @(posedge clk); #1;
      m_start = 1'b0;
      wait_main_done(lat);
      check($sformatf("vec%0d latency", i), lat, 4);
      check($sformatf("vec%0d sum", i), longint'(m_sum), longint'(vecs[i].exp_sum));
      check($sformatf("vec%0d c_out", i), longint'(m_cout), longint'(vecs[i].exp_cout));
`ifdef ADDSUB_OVF_EN
      check($sformatf("vec%0d ovf", i), longint'(m_ovf), longint'(vecs[i].exp_ovf));
`endif
      @(posedge clk); #1;
      check($sformatf("vec%0d done pulse", i), longint'(m_done), 0);
    end

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    // Back-to-back: start held high through CALC and DONE
    e1 = model(16, 64'h8000, 64'h0001, 1'b1);
    e2 = model(16, 64'h1234, 64'h0001, 1'b0);
    m_a = 16'h8000; m_b = 16'h0001; m_select = 1'b1; m_start = 1'b1;
    @(posedge clk); #1;
    m_a = 16'h1234; m_b = 16'h0001; m_select = 1'b0;
    wait_main_done(lat);
    check("b2b first latency", lat, 4);
    check_main_result("b2b first", e1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        m_start = 1'b0;
        check("b2b accepted busy", longint'(m_busy), 1);
        check("b2b sum held", longint'(m_sum), e1.sum);
      end
      if (m_done) begin
        lat = k;
        break;
      end
    end
    check("b2b second spacing", lat, 5);
    check_main_result("b2b second", e2);
    @(posedge clk); #1;
    check("b2b done pulse", longint'(m_done), 0);

    // Start and operand changes during CALC are ignored
    e1 = model(16, 64'h1111, 64'h2222, 1'b0);
    m_a = 16'h1111; m_b = 16'h2222; m_select = 1'b0; m_start = 1'b1;
    @(posedge clk); #1;
    m_a = 16'hFFFF; m_b = 16'hFFFF; m_select = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0; m_a = 16'h0F0F; m_b = 16'hA5A5;
    wait_main_done(lat);
    check("ignore latency", lat, 3);
    check_main_result("ignore", e1);
    @(posedge clk); #1;
    check("ignore done pulse", longint'(m_done), 0);

    // Reset in the second CALC cycle
    m_a = 16'h00FF; m_b = 16'h0F0F; m_select = 1'b0; m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", longint'(m_busy), 0);
    check("abort done", longint'(m_done), 0);
    check("abort sum", longint'(m_sum), 0);
    check("abort c_out", longint'(m_cout), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0004, 1'b0, "post-reset");
    check("post-reset exact sum", longint'(m_sum), 64'h0007);

    // Narrow instances: WIDTH=DIGIT and WIDTH=2*DIGIT
    run_small(4'hE, 4'hC, 1'b1, 4'hD, 4'hD, 1'b0, "small spec");
    check("w4d4 spec sum", longint'(s4_sum), 64'h2);
    check("w4d2 spec sum", longint'(s2_sum), 64'hA);
    for (int i = 0; i < 12; i++) begin
      run_small(4'($urandom), 4'($urandom), 1'($urandom),
                4'($urandom), 4'($urandom), 1'($urandom), $sformatf("small rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
